// File: rtl/rom_pkg.sv
// Shared ROM port constants and the in-flight read tag.
package rom_pkg;

    localparam int unsigned ROM_ADDR_W = 8;
    localparam int unsigned ROM_DATA_W = 16;
    localparam int unsigned ROM_RD_LAT = 1;
    localparam int unsigned NUM_PORTS  = 2;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    // Tag for the ROM read issued last cycle: valid bit plus owning port.
    typedef struct packed {
        logic v;
        logic id;
    } infl_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the pointer names the port that wins a tie.
module rr_arb2
    import rom_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic       gnt_c,
    output logic       gnt_id_c
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Choose a winner among eligible ports and advance the pointer past it.
    always_comb begin
        gnt_c    = 1'b0;
        gnt_id_c = PORT_FETCH;
        rr_ptr_d = rr_ptr_q;
        case (elig)
            2'b01: begin
                gnt_c    = 1'b1;
                gnt_id_c = PORT_FETCH;
            end
            2'b10: begin
                gnt_c    = 1'b1;
                gnt_id_c = PORT_LOAD;
            end
            2'b11: begin
                gnt_c    = 1'b1;
                gnt_id_c = rr_ptr_q;
            end
            default: begin
                gnt_c    = 1'b0;
                gnt_id_c = PORT_FETCH;
            end
        endcase
        if (gnt_c) begin
            rr_ptr_d = ~gnt_id_c;
        end
    end

    // Pointer register; after reset the fetch port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= PORT_FETCH;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-cycle synchronous instruction ROM between the fetch
// and constant-load ports, steering each read word back to its owner.
module rom_arbiter
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr0,
    input  logic [ADDR_W-1:0] i_req_addr1,
    output logic [1:0]        o_resp_valid,
    input  logic [1:0]        i_resp_ready,
    output logic [DATA_W-1:0] o_resp_data0,
    output logic [DATA_W-1:0] o_resp_data1,
    output logic              o_rom_rd,
    output logic [ADDR_W-1:0] o_rom_raddr,
    input  logic [DATA_W-1:0] i_rom_rdata
);

    infl_t             infl_q;
    infl_t             infl_d;
    logic [1:0]        slot_v_q;
    logic [1:0]        slot_v_d;
    logic [DATA_W-1:0] slot_d_q [NUM_PORTS];
    logic [DATA_W-1:0] slot_d_d [NUM_PORTS];

    logic [1:0]        elig_c;
    logic [1:0]        cap_c;
    logic [1:0]        pop_c;
    logic              gnt_c;
    logic              gnt_id_c;

    // A port may issue only with nothing in flight for it and a slot that is
    // empty or draining this cycle; held in reset, nobody is eligible.
    always_comb begin
        elig_c = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            elig_c[1'(p)] = rst_n
                          & i_req_valid[1'(p)]
                          & ~(infl_q.v & (infl_q.id == 1'(p)))
                          & (~slot_v_q[1'(p)] | i_resp_ready[1'(p)]);
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig     (elig_c),
        .gnt_c    (gnt_c),
        .gnt_id_c (gnt_id_c)
    );

    // Drive the ROM and the request handshake straight from the grant.
    always_comb begin
        o_req_ready = '0;
        o_rom_rd    = 1'b0;
        o_rom_raddr = '0;
        if (gnt_c) begin
            o_rom_rd              = 1'b1;
            o_req_ready[gnt_id_c] = 1'b1;
            o_rom_raddr           = (gnt_id_c == PORT_LOAD) ? i_req_addr1 : i_req_addr0;
        end
    end

    // Next state: tag the issued read, capture returning data, drain popped slots.
    always_comb begin
        infl_d.v  = gnt_c;
        infl_d.id = gnt_c ? gnt_id_c : PORT_FETCH;
        cap_c     = '0;
        pop_c     = '0;
        slot_v_d  = slot_v_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            slot_d_d[1'(p)] = slot_d_q[1'(p)];
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cap_c[1'(p)] = infl_q.v & (infl_q.id == 1'(p));
            pop_c[1'(p)] = slot_v_q[1'(p)] & i_resp_ready[1'(p)];
            if (cap_c[1'(p)]) begin
                slot_v_d[1'(p)] = 1'b1;
                slot_d_d[1'(p)] = i_rom_rdata;
            end else if (pop_c[1'(p)]) begin
                slot_v_d[1'(p)] = 1'b0;
            end
        end
    end

    // State register; reset drops any read in flight so its data is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q   <= '0;
            slot_v_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                slot_d_q[1'(p)] <= '0;
            end
        end else begin
            infl_q   <= infl_d;
            slot_v_q <= slot_v_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                slot_d_q[1'(p)] <= slot_d_d[1'(p)];
            end
        end
    end

    assign o_resp_valid = slot_v_q;
    assign o_resp_data0 = slot_d_q[PORT_FETCH];
    assign o_resp_data1 = slot_d_q[PORT_LOAD];

    // Eligibility keeps a slot from being filled and drained in the same cycle.
    a_no_cap_pop: assert property (@(posedge clk) disable iff (!rst_n)
        (cap_c & pop_c) == 2'b00);

    // Every issued read is tracked exactly one ROM latency later.
    a_rd_lat: assert property (@(posedge clk) disable iff (!rst_n)
        o_rom_rd |-> ##ROM_RD_LAT infl_q.v);

    // At most one request is accepted per cycle.
    a_onehot_ready: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(o_req_ready));

endmodule
